ledstrip_driver: RTL and testbench

Parametrised successor to the single-strip NeoPixel serialiser. It streams `LEDS*BYTES_PER_LED` bytes from a synchronous-read pixel RAM onto a WS281x/SK6812 one-wire line. Compared with the current block it adds:
- configurable bytes per LED (RGB or RGBW) and generic bit timings;
- a global brightness scaler;
- prefetch, so every bit period is exact including across byte boundaries;
- free-running continuous refresh and a clean abort.

It sits between the SPI-loaded frame RAM and the strip output pin.

---
 rtl/ledstrip_pkg.sv | 34 +++
 rtl/ledstrip_driver_timer.sv | 38 +++
 rtl/ledstrip_driver.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_ledstrip_driver.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledstrip_pkg.sv
// ----------------------------------------------------------------------------
// ledstrip_pkg
// Shared types and elaboration-time helpers for the WS281x/SK6812 strip driver.
//   state_t   : serialiser FSM states
//   ns_to_tck : nanoseconds -> clock ticks, clamped to at least one tick
//   us_to_tck : microseconds -> clock ticks (latch period, no clamp)
// ----------------------------------------------------------------------------
package ledstrip_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        LOAD,
        HI,
        LO,
        LATCH
    } state_t;

    // A pulse shorter than one clock still has to occupy a whole cycle on the
    // line, so very short timings are clamped to one tick.
    function automatic int ns_to_tck(input longint clk_hz, input longint t_ns);
        longint ticks;
        ticks = (clk_hz * t_ns) / 64'd1_000_000_000;
        if (ticks < 1) begin
            ticks = 1;
        end
        return int'(ticks);
    endfunction

    function automatic int us_to_tck(input longint clk_hz, input longint t_us);
        return int'((clk_hz * t_us) / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/ledstrip_driver_timer.sv
// ----------------------------------------------------------------------------
// led_bit_timer
// Loadable down-counter that times the high, low and latch periods.
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   i_load   : load i_value this cycle (takes priority over counting)
//   i_value  : period length minus one
//   o_zero   : current count is zero, i.e. this is the last cycle of a period
// Loading N-1 therefore yields a period of exactly N cycles.
// ----------------------------------------------------------------------------
module led_bit_timer #(
    parameter int W = 12
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others; blocking here would create ordering
    // dependent simulation and mismatch the synthesised netlist.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/ledstrip_driver.sv
// ----------------------------------------------------------------------------
// ledstrip_driver
// Streams LEDS*BYTES_PER_LED bytes from a synchronous-read pixel RAM onto a
// WS281x/SK6812 one-wire line, MSB first, ascending address, with a global
// brightness scale, byte prefetch and optional continuous refresh.
//   i_clk          : clock (single domain)
//   i_rst_n        : asynchronous active-low reset
//   i_start        : start-frame request, honoured only in IDLE
//   i_abort        : end the current frame early (line low, then latch)
//   i_continuous   : restart automatically after each latch period
//   i_brightness   : global scale, 255 = unscaled
//   o_rd_addr      : pixel RAM byte address
//   i_rd_data      : RAM data, valid one cycle after o_rd_addr
//   o_busy         : high from start acceptance until return to IDLE
//   o_dout         : registered strip data line
//   o_frame_done   : high for one cycle, the final cycle of a completed latch
// ----------------------------------------------------------------------------
module ledstrip_driver
    import ledstrip_pkg::*;
#(
    parameter int     LEDS          = 200,
    parameter int     BYTES_PER_LED = 3,
    parameter longint CLK_HZ        = 50_000_000,
    parameter int     T0H_NS        = 350,
    parameter int     T0L_NS        = 800,
    parameter int     T1H_NS        = 700,
    parameter int     T1L_NS        = 600,
    parameter int     RST_US        = 50,
    localparam int    NB            = LEDS * BYTES_PER_LED,
    localparam int    AW            = $clog2(NB)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_continuous,
    input  logic [7:0]    i_brightness,
    output logic [AW-1:0] o_rd_addr,
    input  logic [7:0]    i_rd_data,
    output logic          o_busy,
    output logic          o_dout,
    output logic          o_frame_done
);

    generate
        if (BYTES_PER_LED != 3 && BYTES_PER_LED != 4) begin : g_bad_bytes_per_led
            $error("ledstrip_driver: BYTES_PER_LED must be 3 (GRB) or 4 (GRBW)");
        end
    endgenerate

    localparam int T0H_TCK = ns_to_tck(CLK_HZ, T0H_NS);
    localparam int T0L_TCK = ns_to_tck(CLK_HZ, T0L_NS);
    localparam int T1H_TCK = ns_to_tck(CLK_HZ, T1H_NS);
    localparam int T1L_TCK = ns_to_tck(CLK_HZ, T1L_NS);
    localparam int RST_TCK = us_to_tck(CLK_HZ, RST_US);
    localparam int CW      = $clog2(RST_TCK + 1);

    // Timer reload values are period-1: the zero cycle is the period's last.
    localparam logic [CW-1:0] T0H_LD = CW'(T0H_TCK - 1);
    localparam logic [CW-1:0] T0L_LD = CW'(T0L_TCK - 1);
    localparam logic [CW-1:0] T1H_LD = CW'(T1H_TCK - 1);
    localparam logic [CW-1:0] T1L_LD = CW'(T1L_TCK - 1);
    localparam logic [CW-1:0] RST_LD = CW'(RST_TCK - 1);

    localparam logic [AW-1:0] LAST_BYTE = AW'(NB - 1);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_bright;
    logic [7:0]    r_shift;
    logic [7:0]    r_next;
    logic [2:0]    r_bit;
    logic [AW-1:0] r_byte;
    logic          r_abort;   // frame was cut short: no o_frame_done
    logic          r_stop;    // no continuous restart after this latch

    logic          w_tmr_load;
    logic [CW-1:0] w_tmr_value;
    logic          w_tmr_zero;

    logic          w_frame_start;
    logic          w_load_first;
    logic          w_load_next;
    logic          w_shift;
    logic          w_capture;
    logic          w_dout_set;
    logic          w_dout_clr;
    logic          w_busy_clr;
    logic          w_abort;
    logic          w_stop;

    logic [15:0]   w_product;
    logic [7:0]    w_scaled;

    // Brightness scale: upper byte of d*(bright+1), so 255 passes data through
    // and 0 blanks it. One multiplier serves both the first load and prefetch.
    assign w_product = {8'h00, i_rd_data} * ({8'h00, r_bright} + 16'd1);
    assign w_scaled  = w_product[15:8];

    led_bit_timer #(
        .W (CW)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_zero  (w_tmr_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default before the case statement;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_load    = 1'b0;
        w_tmr_value   = '0;
        w_frame_start = 1'b0;
        w_load_first  = 1'b0;
        w_load_next   = 1'b0;
        w_shift       = 1'b0;
        w_capture     = 1'b0;
        w_dout_set    = 1'b0;
        w_dout_clr    = 1'b0;
        w_busy_clr    = 1'b0;
        w_abort       = 1'b0;
        w_stop        = 1'b0;

        case (r_state)
            IDLE: begin
                // Start beats abort here; abort means nothing while idle.
                if (i_start) begin
                    w_state_nxt   = PRIME;
                    w_frame_start = 1'b1;
                end
            end

            PRIME: begin
                if (i_abort) begin
                    w_abort = 1'b1;
                end else begin
                    w_state_nxt = LOAD;
                end
            end

            LOAD: begin
                if (i_abort) begin
                    w_abort = 1'b1;
                end else begin
                    w_state_nxt  = HI;
                    w_load_first = 1'b1;
                    w_dout_set   = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = w_scaled[7] ? T1H_LD : T0H_LD;
                end
            end

            HI: begin
                if (i_abort) begin
                    w_abort = 1'b1;
                end else if (w_tmr_zero) begin
                    w_state_nxt = LO;
                    w_dout_clr  = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = r_shift[7] ? T1L_LD : T0L_LD;
                end
            end

            LO: begin
                if (i_abort) begin
                    w_abort = 1'b1;
                end else if (w_tmr_zero) begin
                    // The prefetch address changed at the previous byte
                    // boundary; by the end of the byte's first bit the RAM
                    // latency has long elapsed, so the next byte is taken then.
                    w_capture  = (r_bit == 3'd7);
                    w_tmr_load = 1'b1;
                    if (r_bit != 3'd0) begin
                        w_state_nxt = HI;
                        w_shift     = 1'b1;
                        w_dout_set  = 1'b1;
                        w_tmr_value = r_shift[6] ? T1H_LD : T0H_LD;
                    end else if (r_byte != LAST_BYTE) begin
                        // Straight into the next byte's high phase: no gap.
                        w_state_nxt = HI;
                        w_load_next = 1'b1;
                        w_dout_set  = 1'b1;
                        w_tmr_value = r_next[7] ? T1H_LD : T0H_LD;
                    end else begin
                        w_state_nxt = LATCH;
                        w_tmr_value = RST_LD;
                    end
                end
            end

            LATCH: begin
                w_stop = i_abort;
                if (w_tmr_zero) begin
                    if (i_continuous && !i_abort && !r_stop) begin
                        w_state_nxt   = PRIME;
                        w_frame_start = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_busy_clr  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // An abort drops the line and runs a full-length latch period.
        if (w_abort) begin
            w_state_nxt = LATCH;
            w_dout_clr  = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_value = RST_LD;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bright  <= '0;
            r_shift   <= '0;
            r_next    <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_abort   <= 1'b0;
            r_stop    <= 1'b0;
            o_rd_addr <= '0;
            o_busy    <= 1'b0;
            o_dout    <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_bright  <= i_brightness;
                o_rd_addr <= '0;
                o_busy    <= 1'b1;
                r_abort   <= 1'b0;
                r_stop    <= 1'b0;
            end

            if (w_load_first || w_load_next) begin
                r_shift <= w_load_first ? w_scaled : r_next;
                r_bit   <= 3'd7;
                r_byte  <= w_load_first ? '0 : r_byte + 1'b1;
                // Address runs one byte ahead and parks on the last byte.
                if (o_rd_addr != LAST_BYTE) begin
                    o_rd_addr <= o_rd_addr + 1'b1;
                end
            end

            if (w_shift) begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_bit   <= r_bit - 1'b1;
            end

            if (w_capture) begin
                r_next <= w_scaled;
            end

            if (w_dout_set) begin
                o_dout <= 1'b1;
            end else if (w_dout_clr) begin
                o_dout <= 1'b0;
            end

            if (w_busy_clr) begin
                o_busy <= 1'b0;
            end

            if (w_abort) begin
                r_abort <= 1'b1;
                r_stop  <= 1'b1;
            end else if (w_stop) begin
                r_stop <= 1'b1;
            end
        end
    end

    assign o_frame_done = (r_state == LATCH) && w_tmr_zero && !r_abort;

endmodule

// File: tb/tb_ledstrip_driver.sv
// ----------------------------------------------------------------------------
// tb_ledstrip_driver
// Self-checking bench for ledstrip_driver with LEDS=2, BYTES_PER_LED=3 at
// 50 MHz (T0H=17, T0L=40, T1H=35, T1L=30, RST=2500 ticks). The expected line
// waveform is built cycle by cycle from the pixel bytes and the bit-timing
// rules; the DUT is sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_ledstrip_driver;

    localparam int NB  = 6;
    localparam int AW  = 3;
    localparam int T0H = 17;
    localparam int T0L = 40;
    localparam int T1H = 35;
    localparam int T1L = 30;
    localparam int RST = 2500;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic          i_abort;
    logic          i_continuous;
    logic [7:0]    i_brightness;
    logic [AW-1:0] o_rd_addr;
    logic [7:0]    i_rd_data;
    logic          o_busy;
    logic          o_dout;
    logic          o_frame_done;

    logic [7:0]    mem [NB];

    int checks   = 0;
    int failures = 0;

    // Expected per-cycle line level and frame_done, index 0 = cycle after the
    // accepting edge.
    bit exp_d[$];
    bit exp_f[$];

    always #10 i_clk = ~i_clk;

    // Synchronous-read pixel RAM.
    always @(posedge i_clk) begin
        i_rd_data <= (int'(o_rd_addr) < NB) ? mem[o_rd_addr] : 8'h00;
    end

    ledstrip_driver #(
        .LEDS          (2),
        .BYTES_PER_LED (3)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_continuous (i_continuous),
        .i_brightness (i_brightness),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_busy       (o_busy),
        .o_dout       (o_dout),
        .o_frame_done (o_frame_done)
    );

    // One frame: PRIME and LOAD cycles low, each bit high then low for its
    // timing, then the latch period with frame_done on its final cycle.
    function automatic void append_frame(input int bright);
        int s;
        int h;
        int l;
        exp_d.push_back(1'b0); exp_f.push_back(1'b0);
        exp_d.push_back(1'b0); exp_f.push_back(1'b0);
        for (int j = 0; j < NB; j++) begin
            s = (int'(mem[j]) * (bright + 1)) / 256;
            for (int i = 7; i >= 0; i--) begin
                h = ((s >> i) & 1) != 0 ? T1H : T0H;
                l = ((s >> i) & 1) != 0 ? T1L : T0L;
                for (int c = 0; c < h; c++) begin exp_d.push_back(1'b1); exp_f.push_back(1'b0); end
                for (int c = 0; c < l; c++) begin exp_d.push_back(1'b0); exp_f.push_back(1'b0); end
            end
        end
        for (int r = 0; r < RST; r++) begin
            exp_d.push_back(1'b0);
            exp_f.push_back(r == RST - 1);
        end
    endfunction

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_continuous = 1'b0;
        i_brightness = 8'hFF;
        #25;
        checks++;
        if (o_dout !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0 || o_rd_addr !== '0) begin
            failures++;
            $display("FAIL reset_state: dout=%b busy=%b done=%b addr=%0d, required all 0",
                     o_dout, o_busy, o_frame_done, o_rd_addr);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_dout !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: dout=%b busy=%b, required 0 0", o_dout, o_busy);
        end
    endtask

    // Runs nframes frames (continuous refresh for all but the last) and
    // compares every cycle against the model.
    task automatic run_frames(input string name, input int nframes, input bit noisy,
                              input bit abort_latch);
        int len, last_start;
        int e_d, e_b, e_f, k_d, k_b, k_f;
        bit g_d, g_b, g_f, w_d, w_b, w_f;
        int done_cnt, first_rise, first_done, second_rise, last_addr, oob;
        int addr_q[$];
        int exp_addr[$];
        bit addr_ok;

        exp_d.delete();
        exp_f.delete();
        for (int f = 0; f < nframes; f++) begin
            append_frame(int'(i_brightness));
            for (int a = 0; a < NB; a++) exp_addr.push_back(a);
        end
        len        = exp_d.size();
        last_start = len - len / nframes;
        e_d = 0; e_b = 0; e_f = 0; k_d = -1; k_b = -1; k_f = -1;
        g_d = 0; g_b = 0; g_f = 0;
        done_cnt = 0; first_rise = -1; first_done = -1; second_rise = -1;
        last_addr = -1; oob = 0;
        i_continuous = (nframes > 1) || abort_latch;

        @(negedge i_clk);
        i_start = 1'b1;
        for (int k = 0; k <= len; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            w_b = (k < len);
            w_d = (k < len) ? exp_d[k] : 1'b0;
            w_f = (k < len) ? exp_f[k] : 1'b0;
            if (o_dout !== w_d)       begin if (e_d == 0) begin k_d = k; g_d = o_dout; end e_d++; end
            if (o_busy !== w_b)       begin if (e_b == 0) begin k_b = k; g_b = o_busy; end e_b++; end
            if (o_frame_done !== w_f) begin if (e_f == 0) begin k_f = k; g_f = o_frame_done; end e_f++; end
            if (o_dout === 1'b1 && first_rise < 0) first_rise = k;
            if (o_frame_done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
            end
            if (first_done >= 0 && k > first_done && o_dout === 1'b1 && second_rise < 0) second_rise = k;
            if (k < len) begin
                if (int'(o_rd_addr) >= NB) oob++;
                if (int'(o_rd_addr) != last_addr) begin
                    addr_q.push_back(int'(o_rd_addr));
                    last_addr = int'(o_rd_addr);
                end
            end
            // Drive for the next edge; start pulses while busy must be ignored.
            i_start = 1'b0;
            if (noisy && k < len - 2) i_start = 1'($urandom_range(0, 1));
            if (nframes > 1 && k == last_start) i_continuous = 1'b0;
            i_abort = abort_latch && (k == len - 100);
        end
        i_start = 1'b0; i_abort = 1'b0; i_continuous = 1'b0;

        checks++;
        if (e_d != 0) begin
            failures++;
            $display("FAIL %s dout_wave: %0d bad cycles, first at %0d got %b want %b",
                     name, e_d, k_d, g_d, exp_d[k_d < len ? k_d : 0]);
        end
        checks++;
        if (e_b != 0) begin
            failures++;
            $display("FAIL %s busy_wave: %0d bad cycles, first at %0d got %b", name, e_b, k_b, g_b);
        end
        checks++;
        if (e_f != 0) begin
            failures++;
            $display("FAIL %s done_wave: %0d bad cycles, first at %0d got %b", name, e_f, k_f, g_f);
        end
        checks++;
        if (done_cnt != nframes) begin
            failures++;
            $display("FAIL %s done_count: got %0d want %0d", name, done_cnt, nframes);
        end
        checks++;
        if (first_rise != 2 && exp_d.size() > 2 && exp_d[2] == 1'b1) begin
            failures++;
            $display("FAIL %s first_rise: got cycle %0d want 2", name, first_rise);
        end
        if (nframes > 1) begin
            checks++;
            if (second_rise != first_done + 3) begin
                failures++;
                $display("FAIL %s restart_gap: rise at %0d want %0d", name, second_rise, first_done + 3);
            end
        end
        addr_ok = (addr_q.size() == exp_addr.size()) && (oob == 0);
        if (addr_ok) begin
            for (int i = 0; i < addr_q.size(); i++) begin
                if (addr_q[i] != exp_addr[i]) addr_ok = 1'b0;
            end
        end
        checks++;
        if (!addr_ok) begin
            failures++;
            $display("FAIL %s addr_trace: %0d distinct steps (want %0d), out-of-range cycles %0d",
                     name, addr_q.size(), exp_addr.size(), oob);
        end
    endtask

    task automatic test_single_one_bit();
        mem[0] = 8'h80;
        for (int j = 1; j < NB; j++) mem[j] = 8'h00;
        i_brightness = 8'hFF;
        run_frames("single_one_bit", 1, 1'b0, 1'b0);
    endtask

    task automatic test_byte_boundary();
        mem[0] = 8'hFF;
        for (int j = 1; j < NB; j++) mem[j] = 8'h00;
        i_brightness = 8'hFF;
        run_frames("byte_boundary", 1, 1'b0, 1'b0);
    endtask

    task automatic test_brightness();
        for (int j = 0; j < NB; j++) mem[j] = 8'hFF;
        i_brightness = 8'h7F;
        run_frames("bright_7f", 1, 1'b0, 1'b0);
        for (int j = 0; j < NB; j++) mem[j] = 8'($urandom);
        i_brightness = 8'h00;
        run_frames("bright_00", 1, 1'b0, 1'b0);
    endtask

    task automatic test_random_busy_start();
        for (int j = 0; j < NB; j++) mem[j] = 8'($urandom);
        i_brightness = 8'($urandom);
        run_frames("random_start_while_busy", 1, 1'b1, 1'b0);
    endtask

    task automatic test_continuous();
        for (int j = 0; j < NB; j++) mem[j] = 8'($urandom);
        i_brightness = 8'($urandom_range(128, 255));
        run_frames("continuous", 2, 1'b0, 1'b0);
    endtask

    task automatic test_abort_in_latch();
        for (int j = 0; j < NB; j++) mem[j] = 8'($urandom);
        i_brightness = 8'hFF;
        run_frames("abort_in_latch", 1, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        int k10, rises, k_ab, e_d, e_b, e_f, k_bad;
        bit w_d, w_b, low_next;
        for (int j = 0; j < NB; j++) mem[j] = 8'($urandom);
        i_brightness = 8'hFF;
        exp_d.delete();
        exp_f.delete();
        append_frame(255);
        rises = 0; k10 = -1;
        for (int k = 1; k < exp_d.size() && k10 < 0; k++) begin
            if (exp_d[k] && !exp_d[k-1]) begin
                if (rises == 10) k10 = k;
                rises++;
            end
        end
        k_ab = k10 + 3;   // inside the high phase of bit 10
        e_d = 0; e_b = 0; e_f = 0; k_bad = -1; low_next = 1'b0;
        i_continuous = 1'b1;
        @(negedge i_clk);
        i_start = 1'b1;
        for (int k = 0; k <= k_ab + RST + 2; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (k <= k_ab) begin
                w_d = exp_d[k]; w_b = 1'b1;
            end else begin
                w_d = 1'b0; w_b = (k <= k_ab + RST);
            end
            if (o_dout !== w_d)         begin e_d++; if (k_bad < 0) k_bad = k; end
            if (o_busy !== w_b)         begin e_b++; if (k_bad < 0) k_bad = k; end
            if (o_frame_done !== 1'b0)  e_f++;
            if (k == k_ab + 1) low_next = (o_dout === 1'b0);
            i_start = 1'b0;
            i_abort = (k == k_ab);
        end
        i_abort = 1'b0;
        i_continuous = 1'b0;
        checks++;
        if (!low_next) begin
            failures++;
            $display("FAIL abort_low_next_edge: dout not 0 one edge after abort");
        end
        checks++;
        if (e_d != 0) begin
            failures++;
            $display("FAIL abort_dout_wave: %0d bad cycles, first bad cycle %0d", e_d, k_bad);
        end
        checks++;
        if (e_b != 0) begin
            failures++;
            $display("FAIL abort_busy_to_idle: %0d bad cycles, first bad cycle %0d", e_b, k_bad);
        end
        checks++;
        if (e_f != 0) begin
            failures++;
            $display("FAIL abort_no_frame_done: frame_done high %0d cycles, want 0", e_f);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        for (int j = 0; j < NB; j++) mem[j] = 8'($urandom);
        i_brightness = 8'hFF;
        exp_d.delete();
        exp_f.delete();
        append_frame(255);
        @(negedge i_clk);
        i_start = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            i_start = 1'b0;
        end
        checks++;
        if (o_dout !== exp_d[5] || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_hi: dout=%b busy=%b want %b 1", o_dout, o_busy, exp_d[5]);
        end
        #3;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_dout !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: dout=%b busy=%b done=%b, required 0 without a clock edge",
                     o_dout, o_busy, o_frame_done);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_dout !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_after_mid_reset: %0d cycles not idle, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_one_bit();
        test_byte_boundary();
        test_brightness();
        test_random_busy_start();
        test_continuous();
        test_abort_in_latch();
        test_abort();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
